fetch_queue_unit: RTL and testbench
===================================

// Module: fetch_queue_unit
// PURPOSE
//  Parametrised instruction-fetch front end for the pipelined datapath: owns the PC, issues
//  imem requests, buffers fetched {instr, pc+4} pairs in a DEPTH-entry circular queue that
//  decouples fetch from decode, and applies redirects (branch/jump/jr from MEM) by flushing.
//  Sits between datapath_cache_if (imem side) and the IF/ID pipeline register.
// PARAMETERS
//  PC_INIT  0   PC value after reset
//  DEPTH    4   queue entries; >=2, need not be a power of two
//  WORD_W   32  instruction / address width
// PORTS
//  CLK          in   1               clock, all state updates on posedge
//  nRST         in   1               asynchronous active-low reset
//  ihit         in   1               imem returns imemload this cycle
//  imemload     in   WORD_W          fetched instruction
//  imemREN      out  1               imem read enable
//  imemaddr     out  WORD_W          fetch address (= PC register)
//  deq          in   1               decode consumes head entry this cycle
//  redirect     in   1               taken branch/jump resolved; flush and refetch
//  redirect_pc  in   WORD_W          new PC when redirect=1
//  halt         in   1               stop fetching (sticky until reset)
//  valid_out    out  1               queue non-empty
//  instr_out    out  WORD_W          head instruction; 0 (nop) when empty
//  pc4_out      out  WORD_W          head pc+4; 0 when empty
//  count_out    out  $clog2(DEPTH+1) occupancy
// BEHAVIOUR
//  Reset (async): PC=PC_INIT, rd/wr ptr=0, count=0, halt_q=0; so imemaddr=PC_INIT,
//   imemREN=1, valid_out=0, instr_out=0, pc4_out=0, count_out=0.
//  full = (count==DEPTH); empty = (count==0); pop = deq & ~empty (deq on empty ignored).
//  imemREN = ~halt_q & ~halt & (~full | pop)  (combinational; full+pop same cycle may fetch).
//  push = ihit & imemREN & ~redirect; on push: entry[wr]={imemload, PC+4}, wr advances,
//   PC<=PC+4 (mod 2^WORD_W). ihit while imemREN=0 is ignored, PC unchanged.
//  Pointers wrap DEPTH-1 -> 0 explicitly. count next = count + push - pop; push&pop leaves
//   count unchanged, never exceeds DEPTH, never underflows.
//  Latency: instruction returned on ihit at cycle N is visible at instr_out at N+1 if queue
//   was empty (registered queue, head read combinationally from entry[rd]).
//  Redirect (highest priority): next cycle count=0, rd=wr=0, PC=redirect_pc; same-cycle
//   ihit data and deq are discarded; valid_out=0 next cycle.
//  Halt: halt_q<=1 on halt; once set imemREN=0 forever; queue still drains via deq;
//   redirect while halted still loads PC but no fetch is issued.
//  Simultaneous redirect+halt: both take effect (flush, PC load, halt_q set).
//  Outputs instr_out/pc4_out are forced to 0 whenever empty (pipeline bubble = nop).
// TESTING
//  1 DEPTH=4, reset, ihit=1 each cycle, deq=0 -> after 4 pushes count=4, imemaddr=0x10,
//    imemREN=0, head instr = word fetched at 0x0, pc4_out=0x4.
//  2 Full, deq=1+ihit=1 same cycle -> count stays 4, pc4_out 0x4->0x8, imemaddr 0x10->0x14.
//  3 count=3, redirect=1, redirect_pc=0x200, ihit=1 same cycle -> next cycle count=0,
//    valid_out=0, instr_out=0, imemaddr=0x200; ihit word not enqueued.
//  4 Stream 10 instrs with alternating deq -> pointers wrap, outputs in order, pc4 0x4..0x28.
//  5 halt=1 with count=2 -> imemREN=0 next cycle, two deqs drain queue, later ihit ignored.
//  6 nRST low mid-stream (count=3, PC=0x30) -> immediately PC=PC_INIT, count=0, valid_out=0.

Source files
------------

// File: rtl/fetch_queue_unit.sv
// Instruction-fetch front end: owns the PC, issues imem reads and buffers
// {instr, pc+4} pairs in a DEPTH-entry circular queue ahead of decode.
module fetch_queue_unit #(
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned WORD_W  = 32,
   parameter logic [WORD_W-1:0] PC_INIT = '0
) (
   input  logic                       CLK,
   input  logic                       nRST,
   input  logic                       ihit,
   input  logic [WORD_W-1:0]          imemload,
   output logic                       imemREN,
   output logic [WORD_W-1:0]          imemaddr,
   input  logic                       deq,
   input  logic                       redirect,
   input  logic [WORD_W-1:0]          redirect_pc,
   input  logic                       halt,
   output logic                       valid_out,
   output logic [WORD_W-1:0]          instr_out,
   output logic [WORD_W-1:0]          pc4_out,
   output logic [$clog2(DEPTH+1)-1:0] count_out
);

   localparam int unsigned CW = $clog2(DEPTH+1);
   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WORD_W-1:0] pc_q;
   logic [WORD_W-1:0] pc_plus4;
   logic [PW-1:0]     rd_ptr, wr_ptr;
   logic [PW-1:0]     rd_ptr_inc, wr_ptr_inc;
   logic [CW-1:0]     cnt_q, cnt_next;
   logic              halt_q;
   logic              full, empty, pop, push;

   logic [WORD_W-1:0] instr_q [DEPTH];
   logic [WORD_W-1:0] pc4_q   [DEPTH];

   always_comb begin
      full       = (cnt_q == CW'(DEPTH));
      empty      = (cnt_q == '0);
      pop        = deq & ~empty;
      // A full queue may still fetch when the head leaves in the same cycle.
      imemREN    = ~halt_q & ~halt & (~full | pop);
      push       = ihit & imemREN & ~redirect;
      pc_plus4   = pc_q + WORD_W'(4);
      rd_ptr_inc = (rd_ptr == PW'(DEPTH-1)) ? '0 : rd_ptr + 1'b1;
      wr_ptr_inc = (wr_ptr == PW'(DEPTH-1)) ? '0 : wr_ptr + 1'b1;
      cnt_next   = cnt_q;
      if (push & ~pop)
         cnt_next = cnt_q + 1'b1;
      else if (pop & ~push)
         cnt_next = cnt_q - 1'b1;
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         pc_q   <= PC_INIT;
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt_q  <= '0;
         halt_q <= 1'b0;
      end else begin
         if (halt)
            halt_q <= 1'b1;
         if (redirect) begin
            pc_q   <= redirect_pc;
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt_q  <= '0;
         end else begin
            if (push) begin
               pc_q   <= pc_plus4;
               wr_ptr <= wr_ptr_inc;
            end
            if (pop)
               rd_ptr <= rd_ptr_inc;
            cnt_q <= cnt_next;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (push) begin
         instr_q[wr_ptr] <= imemload;
         pc4_q[wr_ptr]   <= pc_plus4;
      end
   end

   always_comb begin
      imemaddr  = pc_q;
      valid_out = ~empty;
      count_out = cnt_q;
      instr_out = empty ? '0 : instr_q[rd_ptr];
      pc4_out   = empty ? '0 : pc4_q[rd_ptr];
   end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed bench for fetch_queue_unit (DEPTH=4, PC_INIT=0, WORD_W=32).
module tb_fetch_queue_unit;

   logic        CLK, nRST;
   logic        ihit, imemREN, deq, redirect, halt, valid_out;
   logic [31:0] imemload, imemaddr, redirect_pc, instr_out, pc4_out;
   logic [2:0]  count_out;

   int unsigned errors = 0;
   int unsigned checks = 0;

   fetch_queue_unit #(.DEPTH(4), .WORD_W(32), .PC_INIT(32'h0)) dut (
      .CLK(CLK), .nRST(nRST), .ihit(ihit), .imemload(imemload),
      .imemREN(imemREN), .imemaddr(imemaddr), .deq(deq),
      .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
      .valid_out(valid_out), .instr_out(instr_out), .pc4_out(pc4_out),
      .count_out(count_out)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Memory model: each word encodes its own address.
   function automatic logic [31:0] word(input logic [31:0] a);
      return {16'hC0DE, a[15:0]};
   endfunction

   assign imemload = word(imemaddr);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      int unsigned mcnt, sent, popped, cyc;
      logic        mpush, mpop, mren;

      nRST = 1'b0; ihit = 1'b0; deq = 1'b0; redirect = 1'b0;
      redirect_pc = '0; halt = 1'b0;
      #2;
      chk("rst_addr",  imemaddr, 32'h0);
      chk("rst_ren",   32'(imemREN), 32'h1);
      chk("rst_valid", 32'(valid_out), 32'h0);
      chk("rst_instr", instr_out, 32'h0);
      chk("rst_pc4",   pc4_out, 32'h0);
      chk("rst_count", 32'(count_out), 32'h0);
      tick();
      nRST = 1'b1;

      // deq on empty queue is ignored
      deq = 1'b1;
      tick();
      deq = 1'b0;
      chk("deq_empty_count", 32'(count_out), 32'h0);

      // Fill: first word visible one cycle after ihit
      ihit = 1'b1;
      tick();
      chk("lat_count", 32'(count_out), 32'h1);
      chk("lat_instr", instr_out, 32'hC0DE_0000);
      chk("lat_pc4",   pc4_out, 32'h4);
      tick(); tick(); tick();
      chk("full_count", 32'(count_out), 32'h4);
      chk("full_addr",  imemaddr, 32'h10);
      chk("full_ren",   32'(imemREN), 32'h0);
      chk("full_instr", instr_out, 32'hC0DE_0000);
      chk("full_pc4",   pc4_out, 32'h4);
      tick();
      chk("full_hold_addr", imemaddr, 32'h10);

      // Full with deq+ihit together
      deq = 1'b1;
      #1;
      chk("fullpop_ren", 32'(imemREN), 32'h1);
      tick();
      deq = 1'b0;
      chk("fullpop_count", 32'(count_out), 32'h4);
      chk("fullpop_pc4",   pc4_out, 32'h8);
      chk("fullpop_addr",  imemaddr, 32'h14);
      chk("fullpop_instr", instr_out, 32'hC0DE_0004);

      // Drop to 3, then redirect with same-cycle ihit and deq
      ihit = 1'b0; deq = 1'b1;
      tick();
      chk("three_count", 32'(count_out), 32'h3);
      chk("three_pc4",   pc4_out, 32'hC);
      ihit = 1'b1; redirect = 1'b1; redirect_pc = 32'h200;
      tick();
      ihit = 1'b0; deq = 1'b0; redirect = 1'b0;
      chk("redir_count", 32'(count_out), 32'h0);
      chk("redir_valid", 32'(valid_out), 32'h0);
      chk("redir_instr", instr_out, 32'h0);
      chk("redir_pc4",   pc4_out, 32'h0);
      chk("redir_addr",  imemaddr, 32'h200);
      chk("redir_ren",   32'(imemREN), 32'h1);

      // Back to 0 then stream 10 instructions with alternating deq
      redirect = 1'b1; redirect_pc = 32'h0;
      tick();
      redirect = 1'b0;
      mcnt = 0; sent = 0; popped = 0; cyc = 0;
      while (popped < 10 && cyc < 60) begin
         ihit = (sent < 10);
         deq  = cyc[0];
         #1;
         mpop  = deq && (mcnt > 0);
         mren  = (mcnt != 4) || mpop;
         mpush = ihit && mren;
         chk("strm_count", 32'(count_out), 32'(mcnt));
         chk("strm_ren",   32'(imemREN), 32'(mren));
         if (mpop) begin
            chk("strm_pc4",   pc4_out, 32'(4 * (popped + 1)));
            chk("strm_instr", instr_out, word(32'(4 * popped)));
         end
         tick();
         if (mpush) begin sent++; mcnt++; end
         if (mpop)  begin popped++; mcnt--; end
         cyc++;
      end
      chk("strm_done", 32'(popped), 32'd10);
      ihit = 1'b0; deq = 1'b0;
      chk("strm_end_count", 32'(count_out), 32'h0);
      chk("strm_end_addr",  imemaddr, 32'h28);

      // Halt with two entries queued
      ihit = 1'b1;
      tick(); tick();
      ihit = 1'b0;
      chk("h_count", 32'(count_out), 32'h2);
      chk("h_addr",  imemaddr, 32'h30);
      halt = 1'b1;
      #1;
      chk("h_ren_comb", 32'(imemREN), 32'h0);
      tick();
      halt = 1'b0;
      chk("h_ren_q", 32'(imemREN), 32'h0);
      chk("h_pc4_0", pc4_out, 32'h2C);
      ihit = 1'b1; deq = 1'b1;
      tick();
      chk("h_drain1_count", 32'(count_out), 32'h1);
      chk("h_drain1_pc4",   pc4_out, 32'h30);
      chk("h_drain1_addr",  imemaddr, 32'h30);
      tick();
      deq = 1'b0;
      chk("h_drain2_count", 32'(count_out), 32'h0);
      chk("h_drain2_valid", 32'(valid_out), 32'h0);
      tick();
      chk("h_ign_count", 32'(count_out), 32'h0);
      chk("h_ign_addr",  imemaddr, 32'h30);
      redirect = 1'b1; redirect_pc = 32'h400;
      tick();
      redirect = 1'b0;
      chk("h_redir_addr",  imemaddr, 32'h400);
      chk("h_redir_ren",   32'(imemREN), 32'h0);
      chk("h_redir_count", 32'(count_out), 32'h0);
      ihit = 1'b0;

      // Reset clears halt; build count=3, PC=0x30 then async reset mid-cycle
      nRST = 1'b0;
      #1;
      nRST = 1'b1;
      chk("r2_ren", 32'(imemREN), 32'h1);
      redirect = 1'b1; redirect_pc = 32'h24;
      tick();
      redirect = 1'b0;
      ihit = 1'b1;
      tick(); tick(); tick();
      ihit = 1'b0;
      chk("r3_count", 32'(count_out), 32'h3);
      chk("r3_addr",  imemaddr, 32'h30);
      chk("r3_pc4",   pc4_out, 32'h28);
      #2;
      nRST = 1'b0;
      #1;
      chk("arst_addr",  imemaddr, 32'h0);
      chk("arst_count", 32'(count_out), 32'h0);
      chk("arst_valid", 32'(valid_out), 32'h0);
      chk("arst_instr", instr_out, 32'h0);
      chk("arst_ren",   32'(imemREN), 32'h1);
      tick();
      nRST = 1'b1;
      tick();
      chk("post_rst_addr", imemaddr, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
